// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps funct3/funct7 to an ALU op and flags
// encodings the control unit must trap on. Honours EXT_BRANCH_EN.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        is_r,
  input  logic        is_branch,
  output logic [3:0]  alu_control,
  output logic        illegal
);

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       funct7_ok;
  logic       unused_bits;

  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign funct7_ok   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
  assign unused_bits = &{1'b0, instr[24:15], instr[11:0]};

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    if (is_branch) begin
      alu_control = ALU_SUB;
`ifdef EXT_BRANCH_EN
      illegal = (funct3[2:1] == 2'b01);
`else
      illegal = (funct3[2:1] == 2'b01) || funct3[2];
`endif
    end else begin
      case (funct3)
        3'b000:  alu_control = (is_r && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_control = ALU_SLL;
        3'b010:  alu_control = ALU_SLT;
        3'b011:  alu_control = ALU_SLTU;
        3'b100:  alu_control = ALU_XOR;
        3'b101:  alu_control = instr[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
      // I-type upper bits are immediate, except for the shift forms.
      if (is_r || funct3 == 3'b001 || funct3 == 3'b101)
        illegal = !funct7_ok;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM with memory handshake, bus watchdog
// and illegal-instruction trap. Optional macro EXT_BRANCH_EN enables blt/bge/bltu/bgeu.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_src,
  output logic [1:0]  result_src,
  output logic [3:0]  alu_control,
  output logic        illegal_instr,
  output logic        bus_err
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  state_e            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ready, timeout, taken, cond;
  logic              set_illegal, set_bus;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [3:0]        dec_alu;
  logic              dec_illegal;

  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] src_a_c, src_b_c, result_c;
  logic [2:0] imm_c;
  logic [3:0] alu_c;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign ready   = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign timeout = (MAX_WAIT != 0) && !ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  alu_decoder u_alu_decoder (
    .instr       (instr),
    .is_r        (state == S_EXECR),
    .is_branch   (state == S_BRANCH),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  always_comb begin
    cond = 1'b0;
    case (funct3[2:1])
      2'b00:   cond = zero;
`ifdef EXT_BRANCH_EN
      2'b10:   cond = lt;
      2'b11:   cond = ltu;
`endif
      default: cond = 1'b0;
    endcase
    taken = cond ^ funct3[0];
  end

`ifndef EXT_BRANCH_EN
  logic unused_flags;
  assign unused_flags = lt ^ ltu;
`endif

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_bus     = 1'b0;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    adr_src_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    src_a_c     = SRCA_PC;
    src_b_c     = SRCB_RS2;
    imm_c       = IMM_I;
    result_c    = RES_ALUOUT;
    alu_c       = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        src_b_c   = SRCB_FOUR;
        result_c  = RES_ALU;
        if (ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          set_bus    = 1'b1;
        end
      end
      S_DECODE: begin
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        imm_c   = (opcode == OP_BRANCH) ? IMM_B : IMM_J;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          default: begin
            state_next  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a_c    = SRCA_RS1;
        src_b_c    = SRCB_IMM;
        imm_c      = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD, S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = (state == S_MEMWRITE);
        adr_src_c   = 1'b1;
        if (ready) begin
          state_next = (state == S_MEMWRITE) ? S_FETCH : S_MEMWB;
        end else if (timeout) begin
          state_next = S_TRAP;
          set_bus    = 1'b1;
        end
      end
      S_MEMWB: begin
        result_c    = RES_READ;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        src_a_c = SRCA_RS1;
        src_b_c = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        alu_c   = dec_alu;
        if (dec_illegal) begin
          state_next  = S_TRAP;
          set_illegal = 1'b1;
        end else begin
          state_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c = SRCA_RS1;
        alu_c   = dec_alu;
        if (dec_illegal) begin
          state_next  = S_TRAP;
          set_illegal = 1'b1;
        end else begin
          pc_write_c = taken;
          state_next = S_FETCH;
        end
      end
      S_JAL: begin
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        src_a_c    = SRCA_RS1;
        src_b_c    = SRCB_IMM;
        result_c   = RES_ALU;
        pc_write_c = 1'b1;
        state_next = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        src_a_c     = SRCA_OLDPC;
        src_b_c     = SRCB_FOUR;
        result_c    = RES_ALU;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_LUI: begin
        src_a_c    = SRCA_ZERO;
        src_b_c    = SRCB_IMM;
        imm_c      = IMM_U;
        state_next = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_FETCH;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_req_c && !ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (set_illegal)
        illegal_instr <= 1'b1;
      if (set_bus)
        bus_err <= 1'b1;
    end
  end

  // FETCH drives mem_req, so strobes are masked by reset_n to drop them
  // immediately on an asynchronous reset rather than at the next edge.
  assign mem_req     = reset_n & mem_req_c;
  assign mem_write   = reset_n & mem_write_c;
  assign adr_src     = reset_n & adr_src_c;
  assign ir_write    = reset_n & ir_write_c;
  assign pc_write    = reset_n & pc_write_c;
  assign reg_write   = reset_n & reg_write_c;
  assign alu_src_a   = reset_n ? src_a_c  : '0;
  assign alu_src_b   = reset_n ? src_b_c  : '0;
  assign imm_src     = reset_n ? imm_c    : '0;
  assign result_src  = reset_n ? result_c : '0;
  assign alu_control = reset_n ? alu_c    : '0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (MAX_WAIT=16):
// each step drives inputs at the falling edge and checks the full output vector.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        zero, lt, ltu, mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic        illegal_instr, bus_err;

  int total = 0;
  int bad   = 0;

  logic [20:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, imm_src, result_src, alu_control,
                illegal_instr, bus_err};

  multicycle_control_unit #(.MEM_WAIT(1), .MAX_WAIT(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr         (instr),
    .zero          (zero),
    .lt            (lt),
    .ltu           (ltu),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .result_src    (result_src),
    .alu_control   (alu_control),
    .illegal_instr (illegal_instr),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] pk(input logic mr, input logic mw, input logic as,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic [3:0] alu, input logic ill, input logic be);
    return {mr, mw, as, irw, pcw, rw, sa, sb, imm, res, alu, ill, be};
  endfunction

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic step(input logic rdy, input logic [20:0] want, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    chk(tag, obs, want);
  endtask

  // Reset is released just after a rising edge so the next step sees a fresh FETCH.
  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset_outputs", obs, '0);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  logic [20:0] v_f0, v_f1, v_decj, v_decb, v_madr, v_mread, v_mwb, v_br_t, v_br_n;
  logic [20:0] v_jalr, v_link, v_srai, v_sub, v_radd, v_aluwb, v_trap_i, v_trap_b, v_lui;

  initial begin
    v_f0     = pk(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,4'h0,0,0);
    v_f1     = pk(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b10,4'h0,0,0);
    v_decj   = pk(0,0,0,0,0,0,2'b01,2'b01,3'b011,2'b00,4'h0,0,0);
    v_decb   = pk(0,0,0,0,0,0,2'b01,2'b01,3'b010,2'b00,4'h0,0,0);
    v_madr   = pk(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,4'h0,0,0);
    v_mread  = pk(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,4'h0,0,0);
    v_mwb    = pk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b01,4'h0,0,0);
    v_br_t   = pk(0,0,0,0,1,0,2'b10,2'b00,3'b000,2'b00,4'h1,0,0);
    v_br_n   = pk(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b00,4'h1,0,0);
    v_jalr   = pk(0,0,0,0,1,0,2'b10,2'b01,3'b000,2'b10,4'h0,0,0);
    v_link   = pk(0,0,0,0,0,1,2'b01,2'b10,3'b000,2'b10,4'h0,0,0);
    v_srai   = pk(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,4'h9,0,0);
    v_sub    = pk(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b00,4'h1,0,0);
    v_radd   = pk(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b00,4'h0,0,0);
    v_aluwb  = pk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,4'h0,0,0);
    v_trap_i = pk(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,4'h0,1,0);
    v_trap_b = pk(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,4'h0,0,1);
    v_lui    = pk(0,0,0,0,0,0,2'b11,2'b01,3'b100,2'b00,4'h0,0,0);

    reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    instr = 32'h0000_0013;
    #1 chk("reset_initial", obs, '0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Asynchronous reset in the middle of a fetch.
    step(0, v_f0, "fetch_wait");
    step(0, v_f0, "fetch_wait2");
    #2 reset_n = 1'b0;
    #1 chk("midfetch_req_drop", obs, '0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // lw x1,4(x2) with 3-cycle memory latency on both accesses.
    instr = {12'd4, 5'd2, 3'b010, 5'd1, 7'b0000011};
    step(0, v_f0, "lw_fetch1");
    step(0, v_f0, "lw_fetch2");
    step(1, v_f1, "lw_fetch3");
    step(0, v_decj, "lw_decode");
    step(0, v_madr, "lw_memadr");
    step(0, v_mread, "lw_memread1");
    step(0, v_mread, "lw_memread2");
    step(1, v_mread, "lw_memread3");
    step(0, v_mwb, "lw_memwb");

    // bne taken then not taken.
    instr = {7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011};
    zero = 1'b0;
    step(1, v_f1, "bne_t_fetch");
    step(0, v_decb, "bne_t_decode");
    step(0, v_br_t, "bne_taken");
    zero = 1'b1;
    step(1, v_f1, "bne_n_fetch");
    step(0, v_decb, "bne_n_decode");
    step(0, v_br_n, "bne_not_taken");

    // jalr x1,8(x1)
    instr = {12'd8, 5'd1, 3'b000, 5'd1, 7'b1100111};
    step(1, v_f1, "jalr_fetch");
    step(0, v_decj, "jalr_decode");
    step(0, v_jalr, "jalr_jump");
    step(0, v_link, "jalr_link");

    // srai x1,x1,3 then sub x3,x1,x2
    instr = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd1, 7'b0010011};
    step(1, v_f1, "srai_fetch");
    step(0, v_decj, "srai_decode");
    step(0, v_srai, "srai_exec");
    step(0, v_aluwb, "srai_wb");
    instr = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    step(1, v_f1, "sub_fetch");
    step(0, v_decj, "sub_decode");
    step(0, v_sub, "sub_exec");
    step(0, v_aluwb, "sub_wb");

    // lui x5,0x12345
    instr = {20'h12345, 5'd5, 7'b0110111};
    step(1, v_f1, "lui_fetch");
    step(0, v_decj, "lui_decode");
    step(0, v_lui, "lui_exec");
    step(0, v_aluwb, "lui_wb");

    // R-type with funct7=0000001 traps and the flag sticks.
    instr = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    step(1, v_f1, "mul_fetch");
    step(0, v_decj, "mul_decode");
    step(0, v_radd, "mul_execr");
    step(0, v_trap_i, "mul_trap1");
    step(1, v_trap_i, "mul_trap2");
    step(0, v_trap_i, "mul_trap3");

    // bltu: legal only with EXT_BRANCH_EN.
    do_reset();
    instr = {7'd0, 5'd2, 5'd1, 3'b110, 5'd8, 7'b1100011};
    ltu = 1'b1;
    step(1, v_f1, "bltu_fetch");
    step(0, v_decb, "bltu_decode");
`ifdef EXT_BRANCH_EN
    step(0, v_br_t, "bltu_taken");
    step(0, v_f0, "bltu_back_fetch");
`else
    step(0, v_br_n, "bltu_branch");
    step(0, v_trap_i, "bltu_trap");
`endif

    // Watchdog: 16 cycles without ready in FETCH -> bus_err.
    do_reset();
    for (int i = 0; i < 16; i++) step(0, v_f0, "wd_fetch_wait");
    step(0, v_trap_b, "wd_trap");
    step(1, v_trap_b, "wd_trap_held");

    // Ready on the limit cycle completes the fetch normally.
    do_reset();
    instr = {20'h00001, 5'd5, 7'b0110111};
    for (int i = 0; i < 15; i++) step(0, v_f0, "wd2_fetch_wait");
    step(1, v_f1, "wd2_fetch_ready");
    step(0, v_decj, "wd2_decode");
    step(0, v_lui, "wd2_lui");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle RV32I control unit: a Moore FSM plus an ALU decoder that sequences fetch, decode, execute, memory and writeback over several cycles on one shared ALU and one unified memory port.
- Generalises the single-cycle decoder: adds memory-ready handshake, bus-timeout watchdog, jalr/lui, full I/R ALU op set and an illegal-instruction trap.
- Sits between the instruction register / ALU flags and the datapath muxes and enables.

Parameters:
MEM_WAIT, 1, 1 = stall in memory states until mem_ready; 0 = memory assumed single-cycle, mem_ready ignored (treated as 1).
MAX_WAIT, 16, bus-timeout limit in cycles for any memory state; 0 disables the watchdog.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  reset; one clock domain, asynchronous assert, active-low.
instr  in  32  instruction register contents.
zero  in  1  ALU result == 0.
lt  in  1  signed rs1 < rs2.
ltu  in  1  unsigned rs1 < rs2.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access request.
mem_write  out  1  access is a store.
adr_src  out  1  0 = PC, 1 = ALUOut.
ir_write  out  1  load IR and oldPC.
pc_write  out  1  load PC.
reg_write  out  1  register-file write.
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
result_src  out  2  00 ALUOut, 01 read data, 10 ALU result (direct).
alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
illegal_instr  out  1  sticky trap flag.
bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset: reset_n low forces state FETCH, clears the wait counter, illegal_instr and bus_err. All outputs are 0 while reset_n is low, including mem_req, which drops in the same cycle as an asynchronous mid-access reset.
- Outputs:
  - Decoded from state (Moore), except ir_write/pc_write in FETCH and completion in the memory states, which are gated by mem_ready.
  - pc_write in BRANCH is gated by the flags.
  - Unlisted outputs default to 0.
- FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, add, result_src=10. On mem_ready: ir_write=1, pc_write=1, go to DECODE.
- DECODE: src_a=01, src_b=01, imm_src=B for branches and J otherwise, add; ALUOut now holds the target. Dispatch by opcode:
  - 0000011 -> MEMADR; 0100011 -> MEMADR
  - 0110011 -> EXECR; 0010011 -> EXECI
  - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI
  - anything else -> TRAP
- MEMADR: src_a=10, src_b=01, imm_src I (load) or S (store), add. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; on mem_ready -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready -> FETCH.
- EXECR: src_a=10, src_b=00, ALU op from the decoder -> ALUWB. instr[31:25] not 0000000/0100000 -> TRAP.
- EXECI: same as EXECR with src_b=01, imm_src I. Sub is never selected for I-type. funct3=101 with instr[30] selects sra.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: src_a=10, src_b=00, sub, result_src=00. pc_write = taken -> FETCH.
  - beq: zero; bne: !zero
  - blt: lt; bge: !lt
  - bltu: ltu; bgeu: !ltu
  - funct3 010/011 -> TRAP.
- JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1 -> ALUWB (writes oldPC+4).
- JALR: src_a=10, src_b=01, imm_src I, add, result_src=10, pc_write=1 -> JALR_LINK.
- JALR_LINK: src_a=01, src_b=10, add, result_src=10, reg_write=1 -> FETCH. rs1 is read before the rd write, so rd==rs1 is safe.
- LUI: src_a=11, src_b=01, imm_src U, add -> ALUWB.
- TRAP: all strobes 0; illegal_instr=1 or bus_err=1; held until reset.
- Watchdog:
  - Counter increments each cycle mem_req=1 && !mem_ready and clears on any state change.
  - Count reaching MAX_WAIT-1 with no ready -> TRAP with bus_err=1.
  - mem_ready arriving on the same cycle as the limit wins (access completes).

Optional Feature:
EXT_BRANCH_EN
- Defined: all six branch conditions as above.
- Undefined: only beq/bne are legal; funct3 1xx branches -> TRAP with illegal_instr=1; lt/ltu inputs unused.

Decomposition:
- Package ctrl_pkg holds: state enum (4-bit), opcode constants, alu_control codes, imm_src/result_src/src_a/src_b codes.
- Sub-module alu_decoder (combinational): maps instr, the R/I select and the branch select to alu_control and an illegal flag.

Test Plan:
- Reset mid-fetch: assert reset_n=0 while mem_req=1 -> mem_req=0 in the same cycle; after release, state FETCH, all flags 0.
- lw x1,4(x2) with 3-cycle mem_ready delays -> cycles FETCH(3) DECODE MEMADR MEMREAD(3) MEMWB; reg_write=1 only in MEMWB with result_src=01.
- bne with zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0. Instruction returns to FETCH after 3 cycles.
- jalr x1,8(x1) -> pc_write in JALR with result_src=10, then JALR_LINK with reg_write=1, src_a=01, src_b=10.
- srai (funct3=101, instr[30]=1) -> alu_control=1001; R-type with funct7=0000001 -> TRAP, illegal_instr=1 held.
- MAX_WAIT=16, mem_ready held 0 in FETCH -> bus_err=1 after 16 cycles. Repeat with mem_ready on the 16th cycle -> normal DECODE, bus_err=0.
